// File: rtl/logic_unit_seq.sv
// logic_unit_seq: multi-cycle bitwise logic unit for the ALU datapath.
//
// Applies one of eight bitwise operations to N-bit operands, CHUNK bits per
// clock, LSB slice first. A start/done handshake frames each operation. The
// result and flags are registered and only change on the edge that leaves
// DONE (or on reset).
//
// Optional feature: define LOGIC_UNIT_PARITY_EN to add the flagP output
// (XOR reduction of the result, accumulated per slice).
//
// Ports:
//   clk     - clock, rising edge
//   rst     - synchronous active-high reset
//   start   - request, accepted only while ready=1
//   op      - opcode (000 NOT, 001 AND, 010 OR, 011 XOR,
//             100 NAND, 101 NOR, 110 XNOR, 111 PASS), latched on accept
//   a, b    - operands, latched on accept (b unused for NOT and PASS)
//   ready   - high in IDLE
//   busy    - high in BUSY
//   done    - one-cycle pulse in the cycle before result/flags update
//   result  - registered result, held until the next done
//   flagZ   - result == 0
//   flagN   - result[N-1]
//   flagP   - XOR reduction of result (LOGIC_UNIT_PARITY_EN only)

module logic_unit_seq #(
    parameter int unsigned N     = 4,
    parameter int unsigned CHUNK = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         flagZ,
    output logic         flagN
`ifdef LOGIC_UNIT_PARITY_EN
    ,
    output logic         flagP
`endif
);

    localparam int unsigned NSLICE = N / CHUNK;
    localparam int unsigned IdxW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    if (N < 1 || CHUNK < 1 || CHUNK > N || (N % CHUNK) != 0) begin : g_bad_params
        $error("logic_unit_seq: require N >= 1, 1 <= CHUNK <= N and N %% CHUNK == 0");
    end

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [2:0]        op_q, op_d;
    logic [N-1:0]      a_q, a_d;
    logic [N-1:0]      b_q, b_d;
    logic [N-1:0]      work_q, work_d;
    logic              nz_q, nz_d;      // set once any result bit is 1
    logic              load;
    logic [N-1:0]      result_q;
    logic              flagz_q, flagn_q;
`ifdef LOGIC_UNIT_PARITY_EN
    logic              par_q, par_d;
    logic              flagp_q;
`endif

    logic [CHUNK-1:0]  a_sl, b_sl, r_sl;
    int unsigned       base;

    function automatic logic [CHUNK-1:0] slice_op(input logic [2:0] o,
                                                  input logic [CHUNK-1:0] x,
                                                  input logic [CHUNK-1:0] y);
        logic [CHUNK-1:0] r;
        r = '0;
        case (o)
            3'b000:  r = ~x;
            3'b001:  r = x & y;
            3'b010:  r = x | y;
            3'b011:  r = x ^ y;
            3'b100:  r = ~(x & y);
            3'b101:  r = ~(x | y);
            3'b110:  r = ~(x ^ y);
            default: r = x;
        endcase
        return r;
    endfunction

    always_comb begin
        base = 32'(idx_q) * CHUNK;
        a_sl = a_q[base +: CHUNK];
        b_sl = b_q[base +: CHUNK];
        r_sl = slice_op(op_q, a_sl, b_sl);
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        work_d  = work_q;
        nz_d    = nz_q;
`ifdef LOGIC_UNIT_PARITY_EN
        par_d   = par_q;
`endif
        load    = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    op_d    = op;
                    a_d     = a;
                    b_d     = b;
                    work_d  = '0;
                    nz_d    = 1'b0;
`ifdef LOGIC_UNIT_PARITY_EN
                    par_d   = 1'b0;
`endif
                    idx_d   = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                work_d[base +: CHUNK] = r_sl;
                nz_d = nz_q | (|r_sl);
`ifdef LOGIC_UNIT_PARITY_EN
                par_d = par_q ^ (^r_sl);
`endif
                if (idx_q == IdxW'(NSLICE - 1)) begin
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end
            StDone: begin
                // start is deliberately ignored here; outputs load on this exit edge.
                load    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            work_q   <= '0;
            nz_q     <= 1'b0;
            result_q <= '0;
            flagz_q  <= 1'b0;
            flagn_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            work_q  <= work_d;
            nz_q    <= nz_d;
            if (load) begin
                result_q <= work_q;
                flagz_q  <= ~nz_q;
                flagn_q  <= work_q[N-1];
            end
        end
    end

`ifdef LOGIC_UNIT_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            par_q   <= 1'b0;
            flagp_q <= 1'b0;
        end else begin
            par_q <= par_d;
            if (load) begin
                flagp_q <= par_q;
            end
        end
    end

    assign flagP = flagp_q;
`endif

    assign ready  = (state_q == StIdle);
    assign busy   = (state_q == StBusy);
    assign done   = (state_q == StDone);
    assign result = result_q;
    assign flagZ  = flagz_q;
    assign flagN  = flagn_q;

endmodule
